// File: rtl/reactor_pkg.sv
// reactor_pkg
// Shared definitions for the reactor temperature conditioner and the
// reactor protection FSM bench.
//   - temp_state_t : conditioner state encoding (3 bits)
//   - DEFAULT_*    : default sample width, thresholds, debounce and timeout
//   - state_is_unsafe : Moore decode of the sensor level S for a state
//   - sat_inc8     : 8-bit saturating increment for event counters
package reactor_pkg;

    typedef enum logic [2:0] {
        COLD    = 3'd0,
        RISING  = 3'd1,
        HOT     = 3'd2,
        FALLING = 3'd3,
        FAULT   = 3'd4
    } temp_state_t;

    localparam int DEFAULT_TEMP_W      = 10;
    localparam int DEFAULT_HI_THRESH   = 800;
    localparam int DEFAULT_LO_THRESH   = 700;
    localparam int DEFAULT_DEBOUNCE_N  = 4;
    localparam int DEFAULT_TIMEOUT_CYC = 1000;

    // Only the cold side of the hysteresis reports safe; any unknown
    // encoding is treated as unsafe.
    function automatic logic state_is_unsafe(input temp_state_t st);
        return !((st == COLD) || (st == RISING));
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/reactor_sample_watchdog.sv
// reactor_sample_watchdog
// Detects sample starvation: counts consecutive cycles without
// sample_valid and raises a one-cycle timeout pulse on the cycle that
// would bring the count to TIMEOUT_CYC. A sample arriving on that same
// cycle suppresses the pulse.
// Ports:
//   CLOCK        in  rising-edge clock
//   RESET        in  synchronous active-high reset
//   sample_valid in  sample strobe; clears the idle count
//   timeout      out one-cycle starvation pulse (combinational from count)
module reactor_sample_watchdog
    import reactor_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic sample_valid,
    output logic timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt;

    // The pulse fires while the count sits one below the terminal value,
    // so the state machine moves to FAULT on exactly the TIMEOUT_CYC-th
    // idle edge.
    assign timeout = !sample_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle counter restarts after each pulse so a continued gap in FAULT
    // produces a fresh pulse every TIMEOUT_CYC cycles.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            idle_cnt <= '0;
        end else if (sample_valid || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/reactor_temp_conditioner.sv
// reactor_temp_conditioner
// Converts raw core-temperature samples into the sensor level S read by
// the reactor protection FSM. Applies threshold hysteresis with N-sample
// debounce, and forces S=1 (FAULT) when samples stop arriving.
// Optional build macro: REACTOR_TEMP_PEAK_EN adds peak_temp, the largest
// valid sample seen since reset.
// Ports:
//   CLOCK        in  rising-edge clock
//   RESET        in  synchronous active-high reset
//   temp_sample  in  unsigned temperature sample, qualified by sample_valid
//   sample_valid in  one-cycle sample strobe
//   S            out registered sensor level (1 = hot/unsafe)
//   sensor_fault out registered, 1 while in FAULT
//   hot_events   out saturating count of cold-to-hot transitions
//   peak_temp    out maximum valid sample (REACTOR_TEMP_PEAK_EN only)
module reactor_temp_conditioner
    import reactor_pkg::*;
#(
    parameter int TEMP_W      = DEFAULT_TEMP_W,
    parameter int HI_THRESH   = DEFAULT_HI_THRESH,
    parameter int LO_THRESH   = DEFAULT_LO_THRESH,
    parameter int DEBOUNCE_N  = DEFAULT_DEBOUNCE_N,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [TEMP_W-1:0] temp_sample,
    input  logic              sample_valid,
    output logic              S,
    output logic              sensor_fault,
`ifdef REACTOR_TEMP_PEAK_EN
    output logic [TEMP_W-1:0] peak_temp,
`endif
    output logic [7:0]        hot_events
);

    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    temp_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic             is_hot;
    logic             is_cool;
    logic             run_done;

    reactor_sample_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .sample_valid (sample_valid),
        .timeout      (timeout)
    );

    // Strict compares: samples equal to a threshold sit inside the band.
    assign is_hot   = temp_sample > TEMP_W'(HI_THRESH);
    assign is_cool  = temp_sample < TEMP_W'(LO_THRESH);
    assign cnt_inc  = cnt + CNT_W'(1);
    assign run_done = (cnt_inc == CNT_W'(DEBOUNCE_N));

    // Hysteresis FSM with shared debounce counter. Starvation overrides
    // any sample decision, but a sample on the terminal cycle suppresses
    // the timeout inside the watchdog. S and sensor_fault decode the state
    // held before this edge, so they trail the state by one cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state        <= COLD;
            cnt          <= '0;
            S            <= 1'b0;
            sensor_fault <= 1'b0;
            hot_events   <= 8'd0;
        end else begin
            S            <= state_is_unsafe(state);
            sensor_fault <= (state == FAULT);
            if (timeout) begin
                state <= FAULT;
                cnt   <= '0;
            end else if (sample_valid) begin
                case (state)
                    COLD: begin
                        if (is_hot) begin
                            if (run_done) begin
                                state      <= HOT;
                                cnt        <= '0;
                                hot_events <= sat_inc8(hot_events);
                            end else begin
                                state <= RISING;
                                cnt   <= cnt_inc;
                            end
                        end
                    end
                    RISING: begin
                        if (!is_hot) begin
                            state <= COLD;
                            cnt   <= '0;
                        end else if (run_done) begin
                            state      <= HOT;
                            cnt        <= '0;
                            hot_events <= sat_inc8(hot_events);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HOT: begin
                        if (is_cool) begin
                            if (run_done) begin
                                state <= COLD;
                                cnt   <= '0;
                            end else begin
                                state <= FALLING;
                                cnt   <= cnt_inc;
                            end
                        end
                    end
                    FALLING: begin
                        if (!is_cool) begin
                            state <= HOT;
                            cnt   <= '0;
                        end else if (run_done) begin
                            state <= COLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    FAULT: begin
                        // Any value counts: the sensor is alive again, but
                        // re-entry is into HOT so the FSM stays protected.
                        if (run_done) begin
                            state <= HOT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= FAULT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef REACTOR_TEMP_PEAK_EN
    // Peak tracker follows every valid sample, including those in FAULT.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            peak_temp <= '0;
        end else if (sample_valid && (temp_sample > peak_temp)) begin
            peak_temp <= temp_sample;
        end
    end
`endif

endmodule

// File: tb/tb_reactor_temp_conditioner.sv
// tb_reactor_temp_conditioner
// Directed bench for reactor_temp_conditioner at default parameters.
// A table of per-cycle {inputs, expected outputs} records covers the
// hysteresis and debounce paths; hand-written sequences cover timeout,
// FAULT recovery, mid-operation reset, event saturation and, when
// REACTOR_TEMP_PEAK_EN is defined, the peak tracker.
module tb_reactor_temp_conditioner;

    logic       CLOCK;
    logic       RESET;
    logic [9:0] temp_sample;
    logic       sample_valid;
    logic       S;
    logic       sensor_fault;
    logic [7:0] hot_events;
`ifdef REACTOR_TEMP_PEAK_EN
    logic [9:0] peak_temp;
`endif

    int checks;
    int errors;

    typedef struct {
        logic       valid;
        logic [9:0] sample;
        logic       exp_s;
        logic       exp_fault;
        logic [7:0] exp_hot;
    } vec_t;

    vec_t vecs[$];

    reactor_temp_conditioner dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .temp_sample  (temp_sample),
        .sample_valid (sample_valid),
        .S            (S),
        .sensor_fault (sensor_fault),
`ifdef REACTOR_TEMP_PEAK_EN
        .peak_temp    (peak_temp),
`endif
        .hot_events   (hot_events)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Drive one cycle of inputs and return 1 time unit after the edge.
    task automatic applyStimulus(input logic valid, input logic [9:0] sample);
        sample_valid = valid;
        temp_sample  = sample;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_s,
                               input logic exp_fault, input logic [7:0] exp_hot);
        checks++;
        if ({S, sensor_fault, hot_events} !== {exp_s, exp_fault, exp_hot}) begin
            errors++;
            $display("[TB] FAIL %s: got S=%b fault=%b hot=%0d, want S=%b fault=%b hot=%0d",
                     name, S, sensor_fault, hot_events, exp_s, exp_fault, exp_hot);
        end
    endtask

`ifdef REACTOR_TEMP_PEAK_EN
    task automatic checkPeak(input string name, input logic [9:0] exp_peak);
        checks++;
        if (peak_temp !== exp_peak) begin
            errors++;
            $display("[TB] FAIL %s: got peak=%0d, want peak=%0d", name, peak_temp, exp_peak);
        end
    endtask
`endif

    task automatic addVec(input logic v, input logic [9:0] smp, input logic es,
                          input logic ef, input logic [7:0] eh);
        vec_t r;
        r.valid = v; r.sample = smp; r.exp_s = es; r.exp_fault = ef; r.exp_hot = eh;
        vecs.push_back(r);
    endtask

    // Outputs are checked after each edge; S trails the state by one edge.
    initial begin
        checks = 0;
        errors = 0;

        // Rising run of four hot samples
        addVec(1, 810, 0, 0, 0);
        addVec(1, 820, 0, 0, 0);
        addVec(1, 830, 0, 0, 0);
        addVec(1, 840, 0, 0, 1);
        addVec(0,   0, 1, 0, 1);
        // Falling run broken by a band sample, then a full run
        addVec(1, 650, 1, 0, 1);
        addVec(1, 650, 1, 0, 1);
        addVec(1, 750, 1, 0, 1);
        addVec(1, 650, 1, 0, 1);
        addVec(1, 650, 1, 0, 1);
        addVec(1, 650, 1, 0, 1);
        addVec(1, 650, 1, 0, 1);
        addVec(0,   0, 0, 0, 1);
        // Band sample breaks a rising run
        addVec(1, 810, 0, 0, 1);
        addVec(1, 810, 0, 0, 1);
        addVec(1, 790, 0, 0, 1);
        addVec(1, 810, 0, 0, 1);
        addVec(0,   0, 0, 0, 1);
        addVec(1, 700, 0, 0, 1);
        // Threshold boundaries: 801 hot, 700 not cool, 699 cool
        addVec(1, 801, 0, 0, 1);
        addVec(1, 801, 0, 0, 1);
        addVec(1, 801, 0, 0, 1);
        addVec(1, 801, 0, 0, 2);
        addVec(1, 700, 1, 0, 2);
        addVec(1, 700, 1, 0, 2);
        addVec(1, 699, 1, 0, 2);
        addVec(1, 699, 1, 0, 2);
        addVec(1, 699, 1, 0, 2);
        addVec(1, 699, 1, 0, 2);
        addVec(0,   0, 0, 0, 2);
        // 800 is not hot: it must restart the run
        addVec(1, 801, 0, 0, 2);
        addVec(1, 801, 0, 0, 2);
        addVec(1, 801, 0, 0, 2);
        addVec(1, 800, 0, 0, 2);
        addVec(1, 801, 0, 0, 2);
        addVec(1, 801, 0, 0, 2);
        addVec(1, 801, 0, 0, 2);
        addVec(0,   0, 0, 0, 2);
        addVec(0,   0, 0, 0, 2);

        RESET = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(1, 900);
        checkOutput("reset", 0, 0, 0);
`ifdef REACTOR_TEMP_PEAK_EN
        checkPeak("reset_peak", 0);
`endif
        RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sample);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_fault, vecs[i].exp_hot);
        end

        // A sample on the terminal idle cycle prevents the fault
        applyStimulus(1, 100);
        for (int i = 0; i < 999; i++) applyStimulus(0, 0);
        applyStimulus(1, 100);
        applyStimulus(1, 100);
        checkOutput("no_fault_at_999", 0, 0, 2);

        // Full 1000-cycle gap: state moves on the 1000th edge, outputs one later
        for (int i = 0; i < 1000; i++) applyStimulus(0, 0);
        checkOutput("fault_lag", 0, 0, 2);
        applyStimulus(0, 0);
        checkOutput("fault_set", 1, 1, 2);

        // A second gap in FAULT restarts the re-entry count
        applyStimulus(1, 100);
        applyStimulus(1, 100);
        for (int i = 0; i < 1000; i++) applyStimulus(0, 0);
        applyStimulus(1, 100);
        applyStimulus(1, 100);
        applyStimulus(1, 100);
        checkOutput("fault_gap_restart", 1, 1, 2);
        applyStimulus(1, 100);
        checkOutput("fault_exit_lag", 1, 1, 2);
        applyStimulus(0, 0);
        checkOutput("fault_exit_hot", 1, 0, 2);
        for (int i = 0; i < 4; i++) applyStimulus(1, 100);
        applyStimulus(0, 0);
        checkOutput("fault_hot_to_cold", 0, 0, 2);

        // Reset while FALLING with cnt=3; the reset-cycle sample is ignored
        for (int i = 0; i < 4; i++) applyStimulus(1, 900);
        for (int i = 0; i < 3; i++) applyStimulus(1, 100);
        checkOutput("falling_cnt3", 1, 0, 3);
        RESET = 1'b1;
        applyStimulus(1, 900);
        checkOutput("reset_mid", 0, 0, 0);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 900);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("reset_sample_ignored", 0, 0, 0);

        // 256 hot cycles saturate the event counter at 255
        applyStimulus(1, 100);
        for (int r = 0; r < 256; r++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1, 900);
            for (int i = 0; i < 4; i++) applyStimulus(1, 100);
        end
        applyStimulus(0, 0);
        checkOutput("hot_events_sat", 0, 0, 8'd255);

`ifdef REACTOR_TEMP_PEAK_EN
        RESET = 1'b1;
        applyStimulus(0, 0);
        RESET = 1'b0;
        applyStimulus(1, 500);
        checkPeak("peak_500", 500);
        applyStimulus(1, 900);
        checkPeak("peak_900", 900);
        applyStimulus(1, 600);
        checkPeak("peak_hold", 900);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
